seg7_scan_decoder: RTL
======================

# seg7_scan_decoder

Reads a time-multiplexed seven-segment display bus (active-low segment lines plus active-low digit-select lines) and recovers the value on each digit position. It is the reader counterpart of the team's 3-bit/BCD-to-segment encoders and sits between the display driver and NVBoard. Its outputs feed self-checking logic and on-screen debug. Each digit is committed only after its pattern has been stable for a programmable number of cycles. The committed pattern is decoded back to 0–9, with blank and illegal patterns flagged.

## Interface
- DIGITS, 8: number of multiplexed digit positions, range 1–8.
- STABLE, 4: consecutive identical samples required before commit, range 2–255.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- seg_n  input  8  active-low segments: bit7..bit1 = a..g, bit0 = dp.
- an_n  input  DIGITS  active-low digit select; exactly one low bit is legal.
- digits  output  4*DIGITS  decoded value per position; position i is in bits [4i+3:4i].
- dp  output  DIGITS  committed decimal-point state per position, 1 = lit.
- valid  output  DIGITS  1 = the position holds a recognised digit 0–9.
- upd  output  1  one-cycle pulse: a commit occurred.
- upd_idx  output  3  position index of the last commit.
- err  output  1  one-cycle pulse, coincident with upd, when the committed pattern is illegal.

## Operation
- The input stage registers {an_n, seg_n} every cycle into the sample register s.
- The run counter r tracks how long the sample has been stable:
  - If the incoming value equals s and an_n is one-hot, r increments, saturating at STABLE.
  - Otherwise r is set to 1 when an_n is one-hot, or to 0 when it is not.
- FSM states:
  - IDLE: no one-hot sample.
  - SETTLE: r < STABLE.
  - HELD: committed; waiting for a change.
- FSM transitions:
  - IDLE→SETTLE on a one-hot sample.
  - SETTLE→HELD on the edge where r == STABLE; the commit happens on this edge.
  - HELD→SETTLE on a change to another one-hot value.
  - Any state→IDLE on a zero-hot or multi-hot sample.
  - A HELD sample never recommits, regardless of duration.
- Commit to position i (i = index of the low an_n bit) uses a = ~seg_n[7] … g = ~seg_n[1]. Decode table, a..g active-high:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- Commit results by pattern class:
  - Match: digits[i] = value, valid[i] = 1, err = 0.
  - Blank (0000000): digits[i] = 4'hE, valid[i] = 0, err = 0.
  - Any other pattern: digits[i] = 4'hF, valid[i] = 0, err = 1.
- dp[i] = ~seg_n[0] on every commit, independent of decode.
- Positions not being committed keep their values.
- upd_idx updates on every commit and holds otherwise.

## Timing
- Reset values:
  - digits = 0, dp = 0, valid = 0, upd = 0, upd_idx = 0, err = 0.
  - r = 0, s = all-ones, state = IDLE.
- Latency: an input first captured at edge k, and held, commits at edge k+STABLE. Outputs are visible in the cycle after that edge.
- upd and err are high for exactly that one cycle.
- A one-cycle glitch or change during SETTLE restarts the count at r = 1 with the new value; nothing commits.
- A zero-hot or multi-hot select (ghosting between digits) commits nothing and leaves all stored positions unchanged.
- A position index ≥ DIGITS cannot occur: an_n is exactly DIGITS bits wide.
- Reset asserted mid-count clears all state immediately, without waiting for a clock. After release, a full STABLE window is required before any commit.
- Back-to-back positions, each held for exactly STABLE cycles, produce one commit per position with no loss.
- Counter width is clog2(STABLE+1). r never wraps.

## Test plan
- Reset, STABLE=4: drive an_n=8'hFE, seg_n=~8'b1101_1010 from edge 0 → at edge 4, digits[3:0]=2, valid[0]=1, dp[0]=0, upd=1 for one cycle, upd_idx=0.
- Scan digits 0–7 onto positions 0–7, each held for 4 cycles → 8 upd pulses, digits=32'h7654_3210, valid=8'hFF. Digit 0's encoder pattern also lights dp, so dp=8'h01.
- Glitch: hold position 3 with pattern "5" for 3 cycles, 1 cycle of 0xFF selects, then 3 cycles of "5" again → no upd; a 4th stable cycle → commit, digits[15:12]=5.
- Illegal pattern 0110_1100 active-high on position 2 → digits[11:8]=F, valid[2]=0, err=1 coincident with upd. Blank on position 2 → digits[11:8]=E, err=0.
- Multi-hot an_n=8'hFC held for 20 cycles → no upd; all stored positions unchanged.
- Assert rst_n low at r=3 → all outputs 0 immediately. After release, the same input commits only after a full 4-cycle window.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: reads a multiplexed active-low 7-seg bus and
// recovers each digit after a programmable stability window.
module seg7_scan_decoder #(
  parameter int DIGITS = 8,
  parameter int STABLE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     valid,
  output logic                  upd,
  output logic [2:0]            upd_idx,
  output logic                  err
);

  localparam int RW = $clog2(STABLE + 1);
  localparam int SW = DIGITS + 8;
  localparam logic [RW-1:0] RMAX = RW'(STABLE);
  localparam logic [RW-1:0] RONE = RW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_t;

  state_t          state, nstate;
  logic [SW-1:0]   x, s;
  logic [RW-1:0]   r;
  logic            oh, same, commit;
  logic [2:0]      idx;
  logic [6:0]      pat;
  logic [3:0]      val;
  logic            ok, ill;

  assign x    = {an_n, seg_n};
  assign oh   = $onehot(~an_n);
  assign same = (x == s);
  assign pat  = ~s[7:1];

  // sample register and saturating run-length counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '1;
      r <= '0;
    end else begin
      s <= x;
      if (same && oh)
        r <= (r == RMAX) ? r : r + RONE;
      else
        r <= oh ? RONE : '0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // FSM next state: tracks whether the current sample is committed
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (oh) nstate = SETTLE;
      end
      SETTLE: begin
        if (!oh)
          nstate = IDLE;
        else if (same && r == RMAX)
          nstate = HELD;
        else
          nstate = SETTLE;
      end
      HELD: begin
        if (!oh)        nstate = IDLE;
        else if (!same) nstate = SETTLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // FSM output: one commit per stable run
  always_comb begin
    commit = (state == SETTLE) && (r == RMAX);
  end

  // position index of the low select bit in the sample
  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (!s[8+i]) idx = 3'(i);
  end

  // segment pattern back to a digit value
  always_comb begin
    val = 4'hF;
    ok  = 1'b0;
    ill = 1'b0;
    unique case (pat)
      7'b1111110: begin val = 4'd0; ok = 1'b1; end
      7'b0110000: begin val = 4'd1; ok = 1'b1; end
      7'b1101101: begin val = 4'd2; ok = 1'b1; end
      7'b1111001: begin val = 4'd3; ok = 1'b1; end
      7'b0110011: begin val = 4'd4; ok = 1'b1; end
      7'b1011011: begin val = 4'd5; ok = 1'b1; end
      7'b1011111: begin val = 4'd6; ok = 1'b1; end
      7'b1110000: begin val = 4'd7; ok = 1'b1; end
      7'b1111111: begin val = 4'd8; ok = 1'b1; end
      7'b1111011: begin val = 4'd9; ok = 1'b1; end
      7'b0000000: val = 4'hE;
      default:    ill = 1'b1;
    endcase
  end

  // committed per-position results and pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits  <= '0;
      dp      <= '0;
      valid   <= '0;
      upd     <= 1'b0;
      upd_idx <= '0;
      err     <= 1'b0;
    end else begin
      upd <= commit;
      err <= commit && ill;
      if (commit) begin
        digits[{idx, 2'b00} +: 4] <= val;
        dp[idx]                   <= ~s[0];
        valid[idx]                <= ok;
        upd_idx                   <= idx;
      end
    end
  end

endmodule
